// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port memory arbiter with a single registered access FSM
//
// Purpose: shares one memory port between port 0 (instruction fetch, read-only)
// and port 1 (data stage, read/write). One transaction at a time. A misaligned
// winner completes at once with an error flag and never reaches memory.
//
// Configuration macro: ARB_RR_EN
//   defined   - round-robin on simultaneous requests; the port granted last loses the next tie
//   undefined - fixed priority, port 1 wins ties
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req0, adr0               port 0 read request (level) and byte address
//   done0, err0, rdata0      port 0 completion pulse, error flag, read data
//   req1, we1, adr1, wdata1  port 1 request, write enable, byte address, write data
//   done1, err1, rdata1      port 1 completion pulse, error flag, read data
//   m_en, m_we, m_adr,
//   m_wdata, m_rdata         memory access strobe, write enable, address, data
//   busy, owner              arbiter not idle; port holding the current/last grant
module mem_port_arbiter #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] adr0,
  output logic        done0,
  output logic        err0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] adr1,
  input  logic [31:0] wdata1,
  output logic        done1,
  output logic        err1,
  output logic [31:0] rdata1,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_adr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] LAT_W = 3'(READ_LAT);

  state_t      state;
  logic [2:0]  wait_cnt;
  logic        cur_we;
  logic        win;
  logic [31:0] win_adr;

`ifdef ARB_RR_EN
  logic last_grant;

  // On a tie the port that won the previous grant steps aside.
  always_comb begin
    win = req1;
    if (req0 && req1) win = ~last_grant;
  end
`else
  // Port 1 wins whenever it requests.
  always_comb begin
    win = req1;
  end
`endif

  assign win_adr = win ? adr1 : adr0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
      cur_we   <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      rdata0   <= 32'd0;
      rdata1   <= 32'd0;
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      m_adr    <= 32'd0;
      m_wdata  <= 32'd0;
      busy     <= 1'b0;
      owner    <= 1'b0;
`ifdef ARB_RR_EN
      last_grant <= 1'b0;
`endif
    end else begin
      // Strobes and completion flags are single-cycle by default.
      m_en  <= 1'b0;
      m_we  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner   <= win;
            busy    <= 1'b1;
            m_adr   <= win_adr;
            // Port 0 never writes, so it carries no write data.
            m_wdata <= win ? wdata1 : 32'd0;
            cur_we  <= win & we1;
`ifdef ARB_RR_EN
            last_grant <= win;
`endif
            if (win_adr[1:0] != 2'b00) begin
              state <= DONE;
              done0 <= ~win;
              done1 <= win;
              err0  <= ~win;
              err1  <= win;
            end else begin
              state <= ISSUE;
              m_en  <= 1'b1;
              m_we  <= win & we1;
            end
          end
        end
        ISSUE: begin
          if (cur_we) begin
            state <= DONE;
            done0 <= ~owner;
            done1 <= owner;
          end else begin
            state    <= WAIT;
            wait_cnt <= 3'd1;
          end
        end
        WAIT: begin
          // The edge closing the last wait cycle is where memory data is valid.
          if (wait_cnt == LAT_W) begin
            state <= DONE;
            done0 <= ~owner;
            done1 <= owner;
            if (owner) rdata1 <= m_rdata;
            else       rdata0 <= m_rdata;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (READ_LAT 1 and 3 instances)
module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  logic        req0_v [2];
  logic [31:0] adr0_v [2];
  logic        req1_v [2];
  logic        we1_v [2];
  logic [31:0] adr1_v [2];
  logic [31:0] wdata1_v [2];
  logic [31:0] m_rdata_v [2];

  logic        done0_o [2];
  logic        err0_o [2];
  logic [31:0] rdata0_o [2];
  logic        done1_o [2];
  logic        err1_o [2];
  logic [31:0] rdata1_o [2];
  logic        m_en_o [2];
  logic        m_we_o [2];
  logic [31:0] m_adr_o [2];
  logic [31:0] m_wdata_o [2];
  logic        busy_o [2];
  logic        owner_o [2];

  int n_cmp = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  assign m_rdata_v[0] = mem_fn(m_adr_o[0]);
  assign m_rdata_v[1] = mem_fn(m_adr_o[1]);

  mem_port_arbiter #(.READ_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .req0(req0_v[0]), .adr0(adr0_v[0]),
    .done0(done0_o[0]), .err0(err0_o[0]), .rdata0(rdata0_o[0]),
    .req1(req1_v[0]), .we1(we1_v[0]), .adr1(adr1_v[0]), .wdata1(wdata1_v[0]),
    .done1(done1_o[0]), .err1(err1_o[0]), .rdata1(rdata1_o[0]),
    .m_en(m_en_o[0]), .m_we(m_we_o[0]), .m_adr(m_adr_o[0]), .m_wdata(m_wdata_o[0]),
    .m_rdata(m_rdata_v[0]), .busy(busy_o[0]), .owner(owner_o[0])
  );

  mem_port_arbiter #(.READ_LAT(3)) u_dut_l3 (
    .clk(clk), .rst(rst),
    .req0(req0_v[1]), .adr0(adr0_v[1]),
    .done0(done0_o[1]), .err0(err0_o[1]), .rdata0(rdata0_o[1]),
    .req1(req1_v[1]), .we1(we1_v[1]), .adr1(adr1_v[1]), .wdata1(wdata1_v[1]),
    .done1(done1_o[1]), .err1(err1_o[1]), .rdata1(rdata1_o[1]),
    .m_en(m_en_o[1]), .m_we(m_we_o[1]), .m_adr(m_adr_o[1]), .m_wdata(m_wdata_o[1]),
    .m_rdata(m_rdata_v[1]), .busy(busy_o[1]), .owner(owner_o[1])
  );

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got=%h want=%h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Transaction-level model: one transaction per instance, described by its
  // grant port, address, kind and age in cycles since the granting edge.
  bit          act_m [2]   = '{0, 0};
  int          off_m [2]   = '{0, 0};
  int          tlat_m [2]  = '{1, 1};
  bit          tport_m [2] = '{0, 0};
  bit          twe_m [2]   = '{0, 0};
  bit          terr_m [2]  = '{0, 0};
  logic [31:0] tadr_m [2]  = '{0, 0};
  bit          own_m [2]   = '{0, 0};
  logic [31:0] madr_m [2]  = '{0, 0};
  logic [31:0] mwd_m [2]   = '{0, 0};
  logic [31:0] rd0_m [2]   = '{0, 0};
  logic [31:0] rd1_m [2]   = '{0, 0};
  bit          rr_m [2]    = '{0, 0};

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        act_m[d] = 0; own_m[d] = 0; madr_m[d] = 0; mwd_m[d] = 0;
        rd0_m[d] = 0; rd1_m[d] = 0; rr_m[d] = 0; terr_m[d] = 0; off_m[d] = 0;
      end else if (act_m[d]) begin
        off_m[d]++;
        if (off_m[d] == tlat_m[d]) act_m[d] = 0;
        else if (off_m[d] == tlat_m[d] - 1 && !twe_m[d] && !terr_m[d]) begin
          if (tport_m[d]) rd1_m[d] = mem_fn(tadr_m[d]);
          else            rd0_m[d] = mem_fn(tadr_m[d]);
        end
      end else if (req0_v[d] || req1_v[d]) begin
        bit w;
        w = req1_v[d];
`ifdef ARB_RR_EN
        if (req0_v[d] && req1_v[d]) w = !rr_m[d];
`endif
        rr_m[d]    = w;
        act_m[d]   = 1;
        off_m[d]   = 0;
        tport_m[d] = w;
        tadr_m[d]  = w ? adr1_v[d] : adr0_v[d];
        twe_m[d]   = w && we1_v[d];
        terr_m[d]  = (tadr_m[d][1:0] != 2'b00);
        tlat_m[d]  = terr_m[d] ? 1 : (twe_m[d] ? 2 : 2 + lat_of(d));
        own_m[d]   = w;
        madr_m[d]  = tadr_m[d];
        mwd_m[d]   = w ? wdata1_v[d] : 32'd0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      bit en_e;
      bit dn_e;
      en_e = act_m[d] && off_m[d] == 0 && !terr_m[d];
      dn_e = act_m[d] && off_m[d] == tlat_m[d] - 1;
      chk("busy", d, 32'(busy_o[d]), 32'(act_m[d]));
      chk("owner", d, 32'(owner_o[d]), 32'(own_m[d]));
      chk("m_en", d, 32'(m_en_o[d]), 32'(en_e));
      chk("m_we", d, 32'(m_we_o[d]), 32'(en_e && twe_m[d]));
      chk("m_adr", d, m_adr_o[d], madr_m[d]);
      chk("m_wdata", d, m_wdata_o[d], mwd_m[d]);
      chk("done0", d, 32'(done0_o[d]), 32'(dn_e && !tport_m[d]));
      chk("done1", d, 32'(done1_o[d]), 32'(dn_e && tport_m[d]));
      chk("err0", d, 32'(err0_o[d]), 32'(dn_e && !tport_m[d] && terr_m[d]));
      chk("err1", d, 32'(err1_o[d]), 32'(dn_e && tport_m[d] && terr_m[d]));
      chk("rdata0", d, rdata0_o[d], rd0_m[d]);
      chk("rdata1", d, rdata1_o[d], rd1_m[d]);
    end
  end

  // Drive one request pattern on instance d and observe until ntx done pulses.
  task automatic run(input int d, input bit r0, input bit r1,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input bit w1, input logic [31:0] wd, input int ntx, input bit early,
                     output int lat, output bit err_f, output int en_cnt,
                     output logic [31:0] en_adr, output bit en_we, output logic [3:0] grants);
    int k;
    int n;
    k = 0; n = 0; lat = 0; err_f = 0; en_cnt = 0; en_adr = 0; en_we = 0; grants = 0;
    req0_v[d] = r0; req1_v[d] = r1; adr0_v[d] = a0; adr1_v[d] = a1;
    we1_v[d] = w1; wdata1_v[d] = wd;
    while (k < 80 && n < ntx) begin
      @(posedge clk); #1;
      k++;
      if (m_en_o[d]) begin
        en_cnt++; en_adr = m_adr_o[d]; en_we = m_we_o[d];
      end
      if (done0_o[d] || done1_o[d]) begin
        if (n == 0) begin
          lat = k; err_f = err0_o[d] || err1_o[d];
        end
        if (n < 4) grants[n] = done1_o[d];
        n++;
      end
      if (early && k == 1) begin
        req0_v[d] = 0; req1_v[d] = 0;
        adr0_v[d] = 32'hFFFF_FFF1; adr1_v[d] = 32'hFFFF_FFF3;
        we1_v[d] = ~w1; wdata1_v[d] = 32'hBAD0_BAD0;
      end
    end
    req0_v[d] = 0; req1_v[d] = 0;
    if (n < ntx) chk("timeout_dones", d, 32'(n), 32'(ntx));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    bit err_f;
    int en_cnt;
    logic [31:0] en_adr;
    bit en_we;
    logic [3:0] grants;
    int dn_cnt;

    for (int d = 0; d < 2; d++) begin
      req0_v[d] = 0; req1_v[d] = 0; we1_v[d] = 0;
      adr0_v[d] = 0; adr1_v[d] = 0; wdata1_v[d] = 0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", 0, 32'(busy_o[0]), 32'd0);
    chk("rst_done0", 0, 32'(done0_o[0]), 32'd0);
    chk("rst_m_adr", 1, m_adr_o[1], 32'd0);
    chk("rst_rdata1", 1, rdata1_o[1], 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Simultaneous requests held for four completions.
    run(0, 1, 1, 32'h40, 32'h44, 1, 32'h77, 4, 0, lat, err_f, en_cnt, en_adr, en_we, grants);
`ifdef ARB_RR_EN
    chk("tie_grants", 0, 32'(grants), 32'h5);
`else
    chk("tie_grants", 0, 32'(grants), 32'hF);
`endif
    chk("tie_first_lat", 0, 32'(lat), 32'd2);

    // Port 0 read at 0x10.
    run(0, 1, 0, 32'h10, 0, 0, 0, 1, 0, lat, err_f, en_cnt, en_adr, en_we, grants);
    chk("rd0_lat", 0, 32'(lat), 32'd3);
    chk("rd0_en_cnt", 0, 32'(en_cnt), 32'd1);
    chk("rd0_en_adr", 0, en_adr, 32'h10);
    chk("rd0_data", 0, rdata0_o[0], 32'hDEADBEEF);
    run(1, 1, 0, 32'h10, 0, 0, 0, 1, 0, lat, err_f, en_cnt, en_adr, en_we, grants);
    chk("rd0_lat3", 1, 32'(lat), 32'd5);
    chk("rd0_data3", 1, rdata0_o[1], 32'hDEADBEEF);

    // Port 1 write at 0x20.
    run(0, 0, 1, 0, 32'h20, 1, 32'h5, 1, 0, lat, err_f, en_cnt, en_adr, en_we, grants);
    chk("wr1_lat", 0, 32'(lat), 32'd2);
    chk("wr1_err", 0, 32'(err_f), 32'd0);
    chk("wr1_en_cnt", 0, 32'(en_cnt), 32'd1);
    chk("wr1_en_we", 0, 32'(en_we), 32'd1);
    chk("wr1_en_adr", 0, en_adr, 32'h20);

    // Misaligned port 1 read.
    run(0, 0, 1, 0, 32'h22, 0, 0, 1, 0, lat, err_f, en_cnt, en_adr, en_we, grants);
    chk("mis_lat", 0, 32'(lat), 32'd1);
    chk("mis_err", 0, 32'(err_f), 32'd1);
    chk("mis_en_cnt", 0, 32'(en_cnt), 32'd0);

    // Requester drops req and scrambles its inputs right after the grant.
    run(1, 0, 1, 0, 32'h50, 0, 32'h1234, 1, 1, lat, err_f, en_cnt, en_adr, en_we, grants);
    chk("early_lat", 1, 32'(lat), 32'd5);
    chk("early_adr", 1, en_adr, 32'h50);
    chk("early_data", 1, rdata1_o[1], 32'h0050FFAF);

    // Request held past done is served again.
    run(0, 1, 0, 32'h60, 0, 0, 0, 2, 0, lat, err_f, en_cnt, en_adr, en_we, grants);
    chk("held_en_cnt", 0, 32'(en_cnt), 32'd2);

    // Reset during WAIT of a READ_LAT=3 read.
    req0_v[1] = 1; adr0_v[1] = 32'h30;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_busy", 1, 32'(busy_o[1]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_abort_busy", 1, 32'(busy_o[1]), 32'd0);
    chk("rst_abort_done", 1, 32'(done0_o[1]), 32'd0);
    req0_v[1] = 0;
    @(posedge clk); #3;
    rst = 1'b0;
    dn_cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done0_o[1] || done1_o[1]) dn_cnt++;
    end
    chk("rst_no_done", 1, 32'(dn_cnt), 32'd0);
    run(1, 1, 0, 32'h10, 0, 0, 0, 1, 0, lat, err_f, en_cnt, en_adr, en_we, grants);
    chk("post_rst_lat", 1, 32'(lat), 32'd5);
    chk("post_rst_data", 1, rdata0_o[1], 32'hDEADBEEF);

    repeat (2) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
